data_cache_dm: RTL and testbench

DATA_CACHE_DM -- requirements
Module: data_cache_dm

---
 rtl/data_cache_dm.sv | 136 +++++++++++++
 tb/tb_data_cache_dm.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/data_cache_dm.sv
// data_cache_dm: direct-mapped, write-through, no-write-allocate data cache with read statistics.
module data_cache_dm #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_LINES   = 16,
  parameter int MEM_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_rd_en,
  input  logic                  cpu_wr_en,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wr_data,
  output logic [DATA_WIDTH-1:0] cpu_rd_data,
  output logic                  stall,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [15:0]           rd_hit_count,
  output logic [15:0]           rd_miss_count
);
  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = ADDR_WIDTH - IW;
  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam logic [1:0] IDLE = 2'd0, RD_MISS = 2'd1, WR_THRU = 2'd2;
  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NUM_LINES-1:0]  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_d [NUM_LINES];
  logic [TW-1:0]         tag_q [NUM_LINES];
  logic [TW-1:0]         tag_d [NUM_LINES];
  logic [15:0]           hit_q, hit_d, miss_q, miss_d;
  logic [IW-1:0]         cpu_idx, lat_idx;
  logic [TW-1:0]         cpu_tag, lat_tag;
  logic                  cpu_hit, lat_hit, done;
  assign cpu_idx       = cpu_addr[IW-1:0];
  assign cpu_tag       = cpu_addr[ADDR_WIDTH-1:IW];
  assign lat_idx       = addr_q[IW-1:0];
  assign lat_tag       = addr_q[ADDR_WIDTH-1:IW];
  assign cpu_hit       = valid_q[cpu_idx] && tag_q[cpu_idx] == cpu_tag;
  assign lat_hit       = valid_q[lat_idx] && tag_q[lat_idx] == lat_tag;
  assign done          = cnt_q == '0;
  assign mem_addr      = addr_q;
  assign mem_wr_data   = wdata_q;
  assign rd_hit_count  = hit_q;
  assign rd_miss_count = miss_q;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    valid_d     = valid_q;
    data_d      = data_q;
    tag_d       = tag_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    stall       = 1'b0;
    cpu_rd_data = '0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    if (state_q == IDLE) begin
      if (cpu_wr_en) begin
        stall   = 1'b1;
        addr_d  = cpu_addr;
        wdata_d = cpu_wr_data;
        cnt_d   = CW'(MEM_LATENCY - 1);
        state_d = WR_THRU;
      end else if (cpu_rd_en && cpu_hit) begin
        cpu_rd_data = data_q[cpu_idx];
        hit_d       = hit_q + {15'd0, hit_q != 16'hFFFF};
      end else if (cpu_rd_en) begin
        stall   = 1'b1;
        addr_d  = cpu_addr;
        cnt_d   = CW'(MEM_LATENCY - 1);
        miss_d  = miss_q + {15'd0, miss_q != 16'hFFFF};
        state_d = RD_MISS;
      end
    end else if (state_q == RD_MISS) begin
      mem_rd_en = 1'b1;
      stall     = !done;
      cnt_d     = done ? cnt_q : cnt_q - 1'b1;
      if (done) begin
        cpu_rd_data      = mem_rd_data;
        data_d[lat_idx]  = mem_rd_data;
        tag_d[lat_idx]   = lat_tag;
        valid_d[lat_idx] = 1'b1;
        state_d          = IDLE;
      end
    end else if (state_q == WR_THRU) begin
      mem_wr_en = done;
      stall     = !done;
      cnt_d     = done ? cnt_q : cnt_q - 1'b1;
      if (done) begin
        if (lat_hit) data_d[lat_idx] = wdata_q;
        state_d = IDLE;
      end
    end else begin
      state_d = IDLE;
    end
    if (!reset) begin
      stall       = 1'b0;
      cpu_rd_data = '0;
      mem_rd_en   = 1'b0;
      mem_wr_en   = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      valid_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end
  // Line payloads carry no reset; the valid bits alone make them meaningful.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    tag_q  <= tag_d;
  end
endmodule

// File: tb/tb_data_cache_dm.sv
// tb_data_cache_dm: table-driven directed checks of the direct-mapped write-through cache.
module tb_data_cache_dm;
  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd_en, cpu_wr_en;
  logic [31:0] cpu_addr, cpu_wr_data, cpu_rd_data;
  logic        stall, mem_rd_en, mem_wr_en;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
  logic [15:0] rd_hit_count, rd_miss_count;
  logic [31:0] mem [0:255];
  int n_cmp = 0;
  int n_bad = 0;

  data_cache_dm dut (
    .clk(clk), .reset(reset),
    .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en),
    .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data),
    .stall(stall), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .rd_hit_count(rd_hit_count), .rd_miss_count(rd_miss_count)
  );

  always #5 clk = ~clk;
  assign mem_rd_data = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr[7:0]] <= mem_wr_data;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_stall;
    logic [31:0] exp_data;
    int          exp_mrd;
    int          exp_mwr;
    logic [15:0] exp_hit;
    logic [15:0] exp_miss;
  } vec_t;
  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_req(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] wdata, output int nstall, output logic [31:0] rdata,
                        output int nmrd, output int nmwr, output logic [31:0] waddr,
                        output logic [31:0] wdat);
    int cyc;
    nstall = 0; nmrd = 0; nmwr = 0; rdata = 'x; waddr = 'x; wdat = 'x; cyc = 0;
    cpu_wr_en = wr; cpu_rd_en = rd; cpu_addr = addr; cpu_wr_data = wdata;
    forever begin
      @(negedge clk);
      cyc++;
      nmrd += int'(mem_rd_en);
      nmwr += int'(mem_wr_en);
      if (mem_wr_en) begin waddr = mem_addr; wdat = mem_wr_data; end
      if (!stall) begin rdata = cpu_rd_data; break; end
      nstall++;
      if (cyc > 40) begin chk("req_timeout", 32'(cyc), 32'd40); break; end
    end
    @(posedge clk); #1;
    cpu_wr_en = 1'b0; cpu_rd_en = 1'b0;
  endtask

  initial begin
    int ns, nr, nw, cyc;
    logic [31:0] rd, wa, wd;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA0 + i;
    vecs[0]  = '{1'b0, 1'b1, 32'h05, 32'h0,  4, 32'hA5, 4, 0, 16'd0, 16'd1};
    vecs[1]  = '{1'b0, 1'b1, 32'h05, 32'h0,  0, 32'hA5, 0, 0, 16'd1, 16'd1};
    vecs[2]  = '{1'b1, 1'b0, 32'h05, 32'h11, 4, 32'h0,  0, 1, 16'd1, 16'd1};
    vecs[3]  = '{1'b0, 1'b1, 32'h05, 32'h0,  0, 32'h11, 0, 0, 16'd2, 16'd1};
    vecs[4]  = '{1'b1, 1'b0, 32'h25, 32'h77, 4, 32'h0,  0, 1, 16'd2, 16'd1};
    vecs[5]  = '{1'b0, 1'b1, 32'h05, 32'h0,  0, 32'h11, 0, 0, 16'd3, 16'd1};
    vecs[6]  = '{1'b0, 1'b1, 32'h25, 32'h0,  4, 32'h77, 4, 0, 16'd3, 16'd2};
    vecs[7]  = '{1'b0, 1'b1, 32'h15, 32'h0,  4, 32'hB5, 4, 0, 16'd3, 16'd3};
    vecs[8]  = '{1'b0, 1'b1, 32'h05, 32'h0,  4, 32'h11, 4, 0, 16'd3, 16'd4};
    vecs[9]  = '{1'b0, 1'b1, 32'h15, 32'h0,  4, 32'hB5, 4, 0, 16'd3, 16'd5};
    vecs[10] = '{1'b0, 1'b1, 32'h15, 32'h0,  0, 32'hB5, 0, 0, 16'd4, 16'd5};
    vecs[11] = '{1'b1, 1'b1, 32'h03, 32'h33, 4, 32'h0,  0, 1, 16'd4, 16'd5};
    vecs[12] = '{1'b0, 1'b1, 32'h03, 32'h0,  4, 32'h33, 4, 0, 16'd4, 16'd6};
    reset = 1'b0; cpu_rd_en = 1'b1; cpu_wr_en = 1'b0; cpu_addr = 32'h5; cpu_wr_data = 32'h0;
    #12;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_rd_data", cpu_rd_data, 32'd0);
    chk("rst_strobes", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
    chk("rst_counts", {rd_hit_count, rd_miss_count}, 32'd0);
    cpu_rd_en = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("idle_stall", {31'd0, stall}, 32'd0);
    chk("idle_strobes", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
    chk("idle_rd_data", cpu_rd_data, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 13; i++) begin
      do_req(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, ns, rd, nr, nw, wa, wd);
      chk($sformatf("v%0d_stall_cycles", i), 32'(ns), 32'(vecs[i].exp_stall));
      chk($sformatf("v%0d_rd_data", i), rd, vecs[i].exp_data);
      chk($sformatf("v%0d_mem_rd_cycles", i), 32'(nr), 32'(vecs[i].exp_mrd));
      chk($sformatf("v%0d_mem_wr_cycles", i), 32'(nw), 32'(vecs[i].exp_mwr));
      chk($sformatf("v%0d_hit_count", i), {16'd0, rd_hit_count}, {16'd0, vecs[i].exp_hit});
      chk($sformatf("v%0d_miss_count", i), {16'd0, rd_miss_count}, {16'd0, vecs[i].exp_miss});
      if (vecs[i].wr) begin
        chk($sformatf("v%0d_wr_addr", i), wa, vecs[i].addr);
        chk($sformatf("v%0d_wr_data", i), wd, vecs[i].wdata);
      end
    end
    chk("mem5_after_write", mem[5], 32'h11);
    chk("mem25_after_write", mem[8'h25], 32'h77);
    // CPU inputs wander while the write is in flight; only the latched ones may reach memory.
    cpu_wr_en = 1'b1; cpu_addr = 32'h7; cpu_wr_data = 32'h99;
    @(posedge clk); #1;
    cpu_addr = 32'h8; cpu_wr_data = 32'h0; cpu_rd_en = 1'b1;
    cyc = 0; wa = 'x; wd = 'x;
    forever begin
      @(negedge clk);
      cyc++;
      if (mem_wr_en) begin wa = mem_addr; wd = mem_wr_data; end
      if (!stall || cyc > 40) break;
    end
    @(posedge clk); #1 cpu_wr_en = 1'b0; cpu_rd_en = 1'b0;
    chk("hold_cycles", 32'(cyc), 32'd4);
    chk("hold_wr_addr", wa, 32'h7);
    chk("hold_wr_data", wd, 32'h99);
    chk("hold_mem7", mem[7], 32'h99);
    chk("hold_mem8", mem[8], 32'hA8);
    // Reset during the second RD_MISS cycle.
    cpu_rd_en = 1'b1; cpu_addr = 32'h9;
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("pre_rst_mem_rd_en", {31'd0, mem_rd_en}, 32'd1);
    reset = 1'b0; #1;
    chk("mid_rst_mem_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    chk("mid_rst_counts", {rd_hit_count, rd_miss_count}, 32'd0);
    cpu_rd_en = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    do_req(1'b0, 1'b1, 32'h9, 32'h0, ns, rd, nr, nw, wa, wd);
    chk("post_rst_stall", 32'(ns), 32'd4);
    chk("post_rst_rd_data", rd, 32'hA9);
    chk("post_rst_counts", {rd_hit_count, rd_miss_count}, {16'd0, 16'd1});
    do_req(1'b0, 1'b1, 32'h5, 32'h0, ns, rd, nr, nw, wa, wd);
    chk("post_rst_5_miss", 32'(ns), 32'd4);
    chk("post_rst_5_data", rd, 32'h11);
    do_req(1'b0, 1'b1, 32'h9, 32'h0, ns, rd, nr, nw, wa, wd);
    chk("post_rst_9_hit", 32'(ns), 32'd0);
    chk("post_rst_final_counts", {rd_hit_count, rd_miss_count}, {16'd1, 16'd2});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
